// File: rtl/chroma_upsampling.sv
// 4:2:0 -> 4:4:4 chroma upsampler for one 16x16 MCU: buffers 384 input samples,
// then replays Y directly and each chroma sample into its 2x2 block (768 beats).
module chroma_upsampling #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  len_err
);

  localparam logic [8:0] LAST_IN  = 9'd383;
  localparam logic [9:0] LAST_OUT = 10'd767;

  typedef enum logic [1:0] {IDLE, RECEIVE, SEND} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] in_buf [0:383];
  logic [8:0]            rx_cnt;
  logic [9:0]            out_ptr;
  logic [8:0]            src;
  logic                  in_fire, out_fire;

  assign in_fire  = s_axis_tvalid && (state == RECEIVE);
  assign out_fire = m_axis_tready && (state == SEND);

  always_comb begin
    state_nx      = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE: state_nx = RECEIVE;
      RECEIVE: begin
        s_axis_tready = 1'b1;
        if (in_fire && (s_axis_tlast || rx_cnt == LAST_IN)) state_nx = SEND;
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (out_ptr == LAST_OUT);
        if (out_fire && out_ptr == LAST_OUT) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // out_ptr[9:8] selects the plane; within a chroma plane, row>>1 is p[7:5]
  // and col>>1 is p[3:1], so the 8x8 source offset is just their concatenation.
  always_comb begin
    unique case (out_ptr[9:8])
      2'd0:    src = {1'b0, out_ptr[7:0]};
      2'd1:    src = 9'd256 + {3'b000, out_ptr[7:5], out_ptr[3:1]};
      default: src = 9'd320 + {3'b000, out_ptr[7:5], out_ptr[3:1]};
    endcase
    m_axis_tdata = (src < rx_cnt) ? in_buf[src] : '0;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      rx_cnt  <= '0;
      out_ptr <= '0;
      len_err <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          rx_cnt  <= '0;
          out_ptr <= '0;
        end
        RECEIVE: begin
          if (in_fire) begin
            rx_cnt <= rx_cnt + 9'd1;
            if (rx_cnt == LAST_IN)  len_err <= ~s_axis_tlast;
            else if (s_axis_tlast)  len_err <= 1'b1;
            else if (rx_cnt == '0)  len_err <= 1'b0;
          end
        end
        SEND: if (out_fire) out_ptr <= out_ptr + 10'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (in_fire) in_buf[rx_cnt] <= s_axis_tdata;
  end

endmodule
